// File: rtl/i2s_mic_pkg.sv
// Shared frame geometry and helpers for the I2S microphone receiver.
package i2s_mic_pkg;

  localparam int SAMPLE_W   = 24;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  // Left-slot data occupies bit counts 1..SAMPLE_W (one-bit delay after mic_ws falls).
  localparam logic [BIT_CNT_W-1:0] CAP_FIRST = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0] CAP_LAST  = BIT_CNT_W'(SAMPLE_W);

  function automatic logic in_capture_window(input logic [BIT_CNT_W-1:0] bit_cnt);
    return (bit_cnt >= CAP_FIRST) && (bit_cnt <= CAP_LAST);
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock divider: toggles sck every SCK_HALF clk cycles and flags the edges.
module i2s_sck_gen #(
  parameter int SCK_HALF = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] CNT_LAST = 8'(SCK_HALF - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;
  logic       wrap;

  // rise/fall are high in the cycle whose closing clk edge changes sck.
  always_comb begin
    wrap  = (cnt_q == CNT_LAST);
    cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
    sck_d = wrap ? ~sck_q : sck_q;
    rise  = wrap & ~sck_q;
    fall  = wrap & sck_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck = sck_q;

endmodule

// File: rtl/i2s_mic_receiver.sv
// I2S master receiver for a left-strapped MEMS microphone; hands out one
// 24-bit left sample per frame through a valid/ready register with sticky overrun.
module i2s_mic_receiver
  import i2s_mic_pkg::*;
#(
  parameter int SCK_HALF = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mic_sd,
  output logic                       mic_sck,
  output logic                       mic_ws,
  output logic                       mic_lr,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       overrun
);

  logic rise, fall;

  i2s_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .sck   (mic_sck),
    .rise  (rise),
    .fall  (fall)
  );

  logic [BIT_CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                       sd_s1_q, sd_s2_q;
  logic [SAMPLE_W-1:0]        shreg_q, shreg_d;
  logic                       load_q, load_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       valid_q, valid_d;
  logic                       overrun_q, overrun_d;

  always_comb begin
    bit_cnt_d = fall ? bit_cnt_q + BIT_CNT_W'(1) : bit_cnt_q;
    shreg_d   = shreg_q;
    if (rise && in_capture_window(bit_cnt_q))
      shreg_d = {shreg_q[SAMPLE_W-2:0], sd_s2_q};
    // Last data bit lands in shreg on this rise; publish it on the following clk.
    load_d    = rise && (bit_cnt_q == CAP_LAST);

    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load_q) begin
      sample_d = shreg_q;
      valid_d  = 1'b1;
      if (valid_q && !sample_ready)
        overrun_d = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      sd_s1_q   <= 1'b0;
      sd_s2_q   <= 1'b0;
      shreg_q   <= '0;
      load_q    <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      sd_s1_q   <= mic_sd;
      sd_s2_q   <= sd_s1_q;
      shreg_q   <= shreg_d;
      load_q    <= load_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign mic_ws       = bit_cnt_q[BIT_CNT_W-1];
  assign mic_lr       = 1'b0;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule
